// File: rtl/vslc_seg7_scan.sv
// Two-digit multiplexed seven-segment scanner.
// Cycles DIG0 -> DEAD0 -> DIG1 -> DEAD1 with programmable dwell times.
// New values are double-buffered and take effect only at a frame boundary,
// so a frame never shows a mix of old and new digits.
module vslc_seg7_scan #(
   parameter int DIGIT_CYCLES = 2048,
   parameter int DEAD_CYCLES  = 16
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic [1:0] dp_in,
   input  logic       load,
   input  logic       blank,
   input  logic       zero_suppress,
   output logic [6:0] seg,
   output logic       dp,
   output logic       en1,
   output logic       en2,
   output logic       frame_done
);

   localparam int MAX_CYC = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {DIG0, DEAD0, DIG1, DEAD1} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lastCycle;
   logic             transfer;

   // Display word layout: {dp1, dp0, nibble1, nibble0}
   logic [9:0]       disp_q, disp_d;
   logic [9:0]       pend_q, pend_d;
   logic             pendValid_q, pendValid_d;

   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             en1_q, en1_d;
   logic             en2_q, en2_d;
   logic             frameDone_q, frameDone_d;
   logic [3:0]       nib;

   function automatic logic [6:0] hexDecode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // State and dwell counter; reset parks in DEAD1 so the first frame starts cleanly
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q <= DEAD1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: advance when the dwell for the current state has elapsed
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      lastCycle = (state_q == DIG0 || state_q == DIG1) ? (cnt_q == DIG_LAST)
                                                       : (cnt_q == DEAD_LAST);
      if (lastCycle) begin
         cnt_d = '0;
         case (state_q)
            DIG0:    state_d = DEAD0;
            DEAD0:   state_d = DIG1;
            DIG1:    state_d = DEAD1;
            default: state_d = DIG0;
         endcase
      end
      transfer = (state_q == DEAD1) && lastCycle;
   end

   // Double buffer: loads land in pending, pending moves to display at the frame boundary
   always_comb begin
      disp_d      = disp_q;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      if (load) begin
         pend_d = {dp_in, value};
      end
      if (transfer) begin
         if (load) begin
            disp_d = {dp_in, value};
         end else if (pendValid_q) begin
            disp_d = pend_q;
         end
         pendValid_d = 1'b0;
      end else if (load) begin
         pendValid_d = 1'b1;
      end
   end

   // Display and pending buffers
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         disp_q      <= '0;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
      end else begin
         disp_q      <= disp_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
      end
   end

   // Outputs decoded from the upcoming state so the registered pins line up with it
   always_comb begin
      seg_d       = '0;
      dp_d        = 1'b0;
      en1_d       = 1'b0;
      en2_d       = 1'b0;
      nib         = '0;
      frameDone_d = (state_d == DEAD1) && (cnt_d == DEAD_LAST);
      case (state_d)
         DIG0: begin
            nib   = disp_d[3:0];
            en1_d = 1'b1;
            seg_d = hexDecode(nib);
            dp_d  = disp_d[8];
         end
         DIG1: begin
            nib = disp_d[7:4];
            if (!(zero_suppress && nib == 4'h0)) begin
               en2_d = 1'b1;
               seg_d = hexDecode(nib);
               dp_d  = disp_d[9];
            end
         end
         default: ;
      endcase
      if (blank) begin
         seg_d = '0;
         dp_d  = 1'b0;
         en1_d = 1'b0;
         en2_d = 1'b0;
      end
   end

   // Output registers
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         seg_q       <= '0;
         dp_q        <= 1'b0;
         en1_q       <= 1'b0;
         en2_q       <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         en1_q       <= en1_d;
         en2_q       <= en2_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign en1        = en1_q;
   assign en2        = en2_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_vslc_seg7_scan.sv
// Testbench for vslc_seg7_scan: directed scenarios plus random traffic,
// all checked against a frame-position model of the scanner.
module tb_vslc_seg7_scan;

   localparam int DIG  = 4;
   localparam int DEAD = 2;
   localparam int PER  = 2 * (DIG + DEAD);

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] value = '0;
   logic [1:0] dp_in = '0;
   logic       load = 1'b0;
   logic       blank = 1'b0;
   logic       zero_suppress = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic       en1;
   logic       en2;
   logic       frame_done;
   logic [10:0] outVec;

   int testCount = 0;
   int failCount = 0;

   // Reference model: position within the frame plus shown/queued words
   int         pos;
   logic [9:0] dispM;
   logic [9:0] pendM;
   logic       pvM;

   logic [7:0] curValue = '0;
   logic [1:0] curDp = '0;
   logic       curBlank = 1'b0;
   logic       curZs = 1'b0;

   logic [6:0] hexTab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   vslc_seg7_scan #(
      .DIGIT_CYCLES(DIG),
      .DEAD_CYCLES (DEAD)
   ) dut (
      .CLK          (CLK),
      .rst          (rst),
      .value        (value),
      .dp_in        (dp_in),
      .load         (load),
      .blank        (blank),
      .zero_suppress(zero_suppress),
      .seg          (seg),
      .dp           (dp),
      .en1          (en1),
      .en2          (en2),
      .frame_done   (frame_done)
   );

   assign outVec = {seg, dp, en1, en2, frame_done};

   // Free-running clock, period 10
   always #5 CLK = ~CLK;

   // Hard stop in case something hangs
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [10:0] modelOut();
      logic [3:0] nib;
      logic [6:0] s;
      logic       d, e1, e2, fd;
      nib = '0;
      s   = '0;
      d   = 1'b0;
      e1  = 1'b0;
      e2  = 1'b0;
      fd  = (pos == PER - 1);
      if (pos < DIG) begin
         nib = dispM[3:0];
         e1  = 1'b1;
         s   = hexTab[nib];
         d   = dispM[8];
      end else if (pos >= DIG + DEAD && pos < 2 * DIG + DEAD) begin
         nib = dispM[7:4];
         if (!(zero_suppress && nib == 4'h0)) begin
            e2 = 1'b1;
            s  = hexTab[nib];
            d  = dispM[9];
         end
      end
      if (blank) begin
         s  = '0;
         d  = 1'b0;
         e1 = 1'b0;
         e2 = 1'b0;
      end
      return {s, d, e1, e2, fd};
   endfunction

   task automatic modelReset();
      pos   = 2 * DIG + DEAD;
      dispM = '0;
      pendM = '0;
      pvM   = 1'b0;
   endtask

   task automatic modelStep();
      if (pos == PER - 1) begin
         if (load) dispM = {dp_in, value};
         else if (pvM) dispM = pendM;
         pvM = 1'b0;
      end else if (load) begin
         pendM = {dp_in, value};
         pvM   = 1'b1;
      end
      pos = (pos + 1) % PER;
   endtask

   task automatic applyStimulus(input logic [7:0] v, input logic [1:0] d, input logic ld,
                                input logic bl, input logic zs, input string tag);
      logic [10:0] expOut;
      value         = v;
      dp_in         = d;
      load          = ld;
      blank         = bl;
      zero_suppress = zs;
      @(posedge CLK);
      modelStep();
      expOut = modelOut();
      @(negedge CLK);
      checkOutput(tag, 32'(outVec), 32'(expOut));
      checkOutput("enExcl", 32'(en1 & en2), 32'(0));
      load = 1'b0;
   endtask

   task automatic idleStep(input string tag);
      applyStimulus(curValue, curDp, 1'b0, curBlank, curZs, tag);
   endtask

   task automatic runTo(input int target, input string tag);
      int guard = 0;
      while (pos != target && guard < 2 * PER) begin
         idleStep(tag);
         guard++;
      end
      if (pos != target) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL %s_bound: got pos %0d required pos %0d", tag, pos, target);
      end
   endtask

   // Called at a falling edge: asynchronous assert, hold across a rising edge, release
   task automatic doReset(input string tag);
      rst = 1'b1;
      #1;
      checkOutput(tag, 32'(outVec), 32'(0));
      modelReset();
      @(negedge CLK);
      rst = 1'b0;
   endtask

   // Main sequence
   initial begin
      int fdCount;
      modelReset();
      #1;
      checkOutput("rstInit", 32'(outVec), 32'(0));
      @(negedge CLK);
      rst = 1'b0;

      // Reset release timing, numbered from the first cycle after release
      for (int k = 2; k <= 14; k++) begin
         idleStep("rel");
         checkOutput("relEn1", 32'(en1), 32'(k >= 3 && k <= 6));
         checkOutput("relEn2", 32'(en2), 32'(k >= 9 && k <= 12));
         checkOutput("relFd", 32'(frame_done), 32'(k == 2 || k == 14));
         checkOutput("relSeg", 32'(seg), ((k >= 3 && k <= 6) || (k >= 9 && k <= 12)) ? 32'h3F : 32'h0);
      end

      // Load during DIG1 takes effect only in the next frame
      runTo(DIG + DEAD + 1, "toDig1");
      applyStimulus(8'h3A, 2'b10, 1'b1, 1'b0, 1'b0, "ld3A");
      curValue = 8'h3A;
      curDp    = 2'b10;
      runTo(0, "ld3Aframe");
      checkOutput("ld3A_d0", 32'({seg, dp, en1}), 32'({7'h77, 1'b0, 1'b1}));
      runTo(DIG + DEAD, "ld3Adig1");
      checkOutput("ld3A_d1", 32'({seg, dp, en2}), 32'({7'h4F, 1'b1, 1'b1}));

      // Last load in a frame wins; a load on the transfer cycle goes straight to display
      runTo(1, "toLd11");
      applyStimulus(8'h11, 2'b00, 1'b1, 1'b0, 1'b0, "ld11");
      idleStep("gap");
      applyStimulus(8'h22, 2'b00, 1'b1, 1'b0, 1'b0, "ld22");
      curDp = 2'b00;
      runTo(0, "ld22frame");
      checkOutput("ld22_d0", 32'(seg), 32'h5B);
      runTo(PER - 1, "toXfer");
      applyStimulus(8'h55, 2'b00, 1'b1, 1'b0, 1'b0, "ld55");
      checkOutput("ld55_d0", 32'(seg), 32'h6D);
      runTo(PER - 1, "ld55hold");
      idleStep("ld55next");
      checkOutput("ld55_kept", 32'(seg), 32'h6D);

      // Blank for a whole frame, then resume in phase
      runTo(PER - 1, "toBlank");
      curBlank = 1'b1;
      fdCount  = 0;
      for (int b = 0; b < PER; b++) begin
         idleStep("blank");
         fdCount += int'(frame_done);
      end
      checkOutput("blankFd", 32'(fdCount), 32'(1));
      curBlank = 1'b0;
      for (int b = 0; b < PER; b++) idleStep("unblank");

      // Zero suppression of the upper digit
      runTo(1, "toLd07");
      applyStimulus(8'h07, 2'b00, 1'b1, 1'b0, 1'b0, "ld07");
      curValue = 8'h07;
      curZs    = 1'b1;
      runTo(0, "zsFrame");
      checkOutput("zs_d0", 32'({seg, en1}), 32'({7'h07, 1'b1}));
      for (int z = 0; z < PER; z++) begin
         idleStep("zs");
         checkOutput("zsEn2", 32'(en2), 32'(0));
      end
      curZs = 1'b0;

      // Reset mid-DIG0 with a load pending
      runTo(1, "toRst");
      applyStimulus(8'h99, 2'b11, 1'b1, 1'b0, 1'b0, "ld99");
      curValue = 8'h99;
      curDp    = 2'b11;
      doReset("rstMid");
      runTo(0, "postRst");
      checkOutput("postRst_d0", 32'({seg, dp, en1}), 32'({7'h3F, 1'b0, 1'b1}));
      runTo(DIG + DEAD, "postRstDig1");
      checkOutput("postRst_d1", 32'({seg, dp, en2}), 32'({7'h3F, 1'b0, 1'b1}));

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] v;
         logic [1:0] d;
         logic       ld;
         v  = 8'($urandom);
         d  = 2'($urandom);
         ld = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) v[7:4] = 4'h0;
         if ($urandom_range(0, 19) == 0) curBlank = ~curBlank;
         if ($urandom_range(0, 29) == 0) curZs = ~curZs;
         if (i == 200) doReset("rstRand");
         applyStimulus(v, d, ld, curBlank, curZs, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
